// File: rtl/inst_cache_fetch.sv
// Direct-mapped read-only instruction cache. Hits are served combinationally
// from IDLE; misses refill one line word by word over a req/ready handshake,
// then a one-cycle bubble lets the stalled fetch retry as a hit.
module inst_cache_fetch #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic                  invalidate,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    input  logic                  imem_ready,
    output logic [31:0]           miss_count
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - 2 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;

    state_t            state;
    logic [31:0]       data_mem [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic [OFF_W-1:0]  cnt;

    logic [OFF_W-1:0]  addr_off;
    logic [IDX_W-1:0]  addr_idx;
    logic [TAG_W-1:0]  addr_tag;
    logic              hit;
    logic              fill_wr;
    logic              unused_byte_bits;

    assign addr_off = fetch_addr[2 +: OFF_W];
    assign addr_idx = fetch_addr[OFF_W+2 +: IDX_W];
    assign addr_tag = fetch_addr[ADDR_WIDTH-1 -: TAG_W];
    // Byte-within-word bits never select anything.
    assign unused_byte_bits = ^fetch_addr[1:0];

    // Hits only come out of IDLE so a refill never races a lookup.
    assign hit        = (state == IDLE) && fetch_req && valid[addr_idx] &&
                        (tag_mem[addr_idx] == addr_tag);
    assign inst_valid = hit;
    assign inst       = hit ? data_mem[addr_idx][addr_off] : 32'h0;

    // An invalidate in the same cycle as a beat aborts it, so skip the write.
    assign fill_wr = (state == REFILL) && imem_ready && !invalidate;

    // Line storage: data and tags carry no reset, the valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill_wr) begin
            data_mem[fill_idx][cnt] <= imem_data;
            if (cnt == LAST_WORD)
                tag_mem[fill_idx] <= fill_tag;
        end
    end

    // Refill controller with registered memory-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            cnt        <= '0;
            fill_idx   <= '0;
            fill_tag   <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (invalidate) begin
                        valid <= '0;
                    end else if (fetch_req && !hit) begin
                        // Line is being overwritten; keep it invalid until complete.
                        valid[addr_idx] <= 1'b0;
                        fill_idx   <= addr_idx;
                        fill_tag   <= addr_tag;
                        cnt        <= '0;
                        imem_req   <= 1'b1;
                        imem_addr  <= {fetch_addr[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                        if (miss_count != 32'hFFFF_FFFF)
                            miss_count <= miss_count + 32'd1;
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (invalidate) begin
                        valid    <= '0;
                        imem_req <= 1'b0;
                        state    <= IDLE;
                    end else if (imem_ready) begin
                        cnt       <= cnt + 1'b1;
                        imem_addr <= imem_addr + ADDR_WIDTH'(4);
                        if (cnt == LAST_WORD) begin
                            valid[fill_idx] <= 1'b1;
                            imem_req        <= 1'b0;
                            state           <= FILL_DONE;
                        end
                    end
                end
                FILL_DONE: begin
                    if (invalidate)
                        valid <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_cache_fetch.sv
// Directed bench for inst_cache_fetch: memory returns 0xC0DE0000 | addr[15:0].
module tb_inst_cache_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        invalidate;
    logic [31:0] inst;
    logic        inst_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic [31:0] miss_count;

    logic        ready_tie = 1'b0;
    logic        lat_mode  = 1'b0;
    logic [1:0]  lat_cnt   = 2'd0;

    int n_checks = 0;
    int n_fail   = 0;

    inst_cache_fetch dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .invalidate(invalidate), .inst(inst), .inst_valid(inst_valid),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .imem_ready(imem_ready), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    assign imem_data  = 32'hC0DE_0000 | {16'h0, imem_addr[15:0]};
    assign imem_ready = ready_tie | (lat_mode & imem_req & (lat_cnt == 2'd1));

    // Latency mode: ready on the second cycle of each outstanding word.
    always @(posedge clk) begin
        if (!imem_req || imem_ready) lat_cnt <= 2'd0;
        else                         lat_cnt <= lat_cnt + 2'd1;
    end

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        exp_valid;
        logic [31:0] exp_inst;
    } vec_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:2], 2'b00};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue a fetch and hold it until served; checks refill addresses, address
    // stability while waiting on ready, stall length and the returned word.
    task automatic fetch_until_hit(input logic [31:0] a, input int exp_lat, input string nm);
        int          cyc  = 0;
        int          w    = 0;
        logic        done = 1'b0;
        logic        preq = 1'b0;
        logic        prdy = 1'b0;
        logic [31:0] paddr = 32'h0;
        logic [31:0] base = a & ~32'hF;
        fetch_req  = 1'b1;
        fetch_addr = a;
        while (!done && cyc < 60) begin
            @(negedge clk);
            if (imem_req && imem_ready) begin
                chk({nm, " refill addr"}, imem_addr, base + 32'(4 * w));
                w++;
            end
            if (imem_req && preq && !prdy)
                chk({nm, " addr hold"}, imem_addr, paddr);
            preq  = imem_req;
            prdy  = imem_ready;
            paddr = imem_addr;
            if (inst_valid) done = 1'b1;
            else begin
                next_cycle();
                cyc++;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no inst_valid within 60 cycles", nm);
        end
        chk({nm, " latency"}, 32'(cyc), 32'(exp_lat));
        chk({nm, " inst"}, inst, mem_word(a));
        chk({nm, " words"}, 32'(w), (exp_lat == 0) ? 32'd0 : 32'd4);
        next_cycle();
        fetch_req = 1'b0;
    endtask

    vec_t hits [7];

    initial begin
        hits[0] = '{1'b1, 32'h0000_0004, 1'b1, 32'hC0DE_0004};
        hits[1] = '{1'b1, 32'h0000_0008, 1'b1, 32'hC0DE_0008};
        hits[2] = '{1'b1, 32'h0000_000C, 1'b1, 32'hC0DE_000C};
        hits[3] = '{1'b1, 32'h0000_0000, 1'b1, 32'hC0DE_0000};
        hits[4] = '{1'b1, 32'h0000_0006, 1'b1, 32'hC0DE_0004};
        hits[5] = '{1'b0, 32'h0000_0004, 1'b0, 32'h0000_0000};
        hits[6] = '{1'b1, 32'h0000_000F, 1'b1, 32'hC0DE_000C};

        reset = 1'b1; fetch_req = 1'b0; fetch_addr = 32'h0; invalidate = 1'b0;
        #3;
        chk("reset inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("reset inst", inst, 32'h0);
        chk("reset imem_req", {31'h0, imem_req}, 32'h0);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset miss_count", miss_count, 32'h0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // 1: cold miss on 0x0, ready tied high, served 6 cycles after the miss
        ready_tie = 1'b1;
        fetch_until_hit(32'h0, 6, "t1");
        chk("t1 miss_count", miss_count, 32'd1);

        // 2: rest of the line hits in the same cycle, no memory traffic
        for (int i = 0; i < 7; i++) begin
            fetch_req  = hits[i].req;
            fetch_addr = hits[i].addr;
            @(negedge clk);
            chk($sformatf("t2 valid %0d", i), {31'h0, inst_valid}, {31'h0, hits[i].exp_valid});
            chk($sformatf("t2 inst %0d", i), inst, hits[i].exp_inst);
            chk($sformatf("t2 imem_req %0d", i), {31'h0, imem_req}, 32'h0);
            next_cycle();
        end
        fetch_req = 1'b0;
        chk("t2 miss_count", miss_count, 32'd1);

        // 3: conflict on index 0 evicts and re-misses
        fetch_until_hit(32'h100, 6, "t3a");
        chk("t3 miss_count a", miss_count, 32'd2);
        fetch_until_hit(32'h0, 6, "t3b");
        chk("t3 miss_count b", miss_count, 32'd3);

        // 4: two cycles per word
        ready_tie = 1'b0;
        lat_mode  = 1'b1;
        fetch_until_hit(32'h40, 10, "t4");
        lat_mode  = 1'b0;
        ready_tie = 1'b1;
        for (int k = 1; k < 4; k++) begin
            fetch_req  = 1'b1;
            fetch_addr = 32'h40 + 32'(4 * k);
            @(negedge clk);
            chk($sformatf("t4 word %0d", k), inst, mem_word(32'h40 + 32'(4 * k)));
            next_cycle();
        end
        fetch_req = 1'b0;
        chk("t4 miss_count", miss_count, 32'd4);

        // 5: invalidate on the second refill word of 0x80
        fetch_req  = 1'b1;
        fetch_addr = 32'h80;
        next_cycle();                 // cycle 1: word 0
        next_cycle();                 // cycle 2: word 1
        invalidate = 1'b1;
        @(negedge clk);
        chk("t5 req during word1", {31'h0, imem_req}, 32'h1);
        next_cycle();
        invalidate = 1'b0;
        fetch_req  = 1'b0;
        @(negedge clk);
        chk("t5 req dropped", {31'h0, imem_req}, 32'h0);
        chk("t5 inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("t5 miss_count", miss_count, 32'd5);
        next_cycle();
        fetch_until_hit(32'h80, 6, "t5 refetch");
        fetch_until_hit(32'h0, 6, "t5 line0");
        chk("t5 miss_count end", miss_count, 32'd7);

        // 6: reset mid-refill, then stray ready pulses with no request
        fetch_req  = 1'b1;
        fetch_addr = 32'h200;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        #1;
        chk("t6 inst_valid", {31'h0, inst_valid}, 32'h0);
        chk("t6 imem_req", {31'h0, imem_req}, 32'h0);
        chk("t6 miss_count", miss_count, 32'h0);
        fetch_req = 1'b0;
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t6 stray req %0d", k), {31'h0, imem_req}, 32'h0);
            next_cycle();
        end
        fetch_until_hit(32'h200, 6, "t6 refetch");
        chk("t6 miss_count end", miss_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
